// File: rtl/face_filter_pkg.sv
// Shared definitions for the face result writer: box/header layout, addresses, FSM states.
// Readback support in the top is selected by FACE_RESULT_WRITER_READBACK_EN.
package face_filter_pkg;

   localparam int unsigned BOX_X_LSB     = 22;
   localparam int unsigned BOX_Y_LSB     = 12;
   localparam int unsigned BOX_SIZE_LSB  = 4;
   localparam int unsigned BOX_SCORE_LSB = 0;

   localparam int unsigned HDR_FCNT_LSB = 16;
   localparam int unsigned HDR_OVF_BIT  = 15;
   localparam int unsigned HDR_CNT_LSB  = 0;

   localparam logic [4:0] HDR_ADDR      = 5'd0;
   localparam logic [4:0] BOX_BASE_ADDR = 5'd1;

   typedef enum logic [2:0] {
      StIdle,
      StWrbox,
      StFlush,
      StHdr,
      StVerify
   } frw_state_e;

   function automatic logic [31:0] make_header(input logic [15:0] fcnt, input logic ovf,
                                               input logic [7:0] cnt);
      return {fcnt, ovf, 7'b0, cnt};
   endfunction

endpackage

// File: rtl/frw_fifo.sv
// Synchronous box FIFO with full/empty flags; head word is visible combinationally on rdata_o.
module frw_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_i && !full_o) wptr_q <= wptr_q + PtrOne;
         if (pop_i && !empty_o) rptr_q <= rptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/face_result_writer.sv
// Buffers detected face boxes and writes them plus a per-frame header into a small register file.
// Define FACE_RESULT_WRITER_READBACK_EN to read back and verify every write (rb_err output).
module face_result_writer
   import face_filter_pkg::*;
#(
   parameter int unsigned MAX_BOXES  = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        box_valid,
   output logic        box_ready,
   input  logic [31:0] box_data,
   input  logic        frame_end,
   output logic [4:0]  mem_address,
   output logic        mem_chipselect,
   output logic        mem_clken,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_byteenable,
   input  logic [31:0] mem_readdata,
   output logic        busy,
   output logic        frame_dropped
`ifdef FACE_RESULT_WRITER_READBACK_EN
   ,
   output logic        rb_err
`endif
);

   localparam logic [7:0] MaxCnt = 8'(MAX_BOXES);

   frw_state_e  state_q, state_d;
   logic [7:0]  count_q, count_d;
   logic        ovf_q, ovf_d;
   logic [15:0] fcnt_q, fcnt_d;
   logic        ready_en_q;

   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [31:0] fifo_rdata;

   logic        acc, wr;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        flush_phase;

`ifdef FACE_RESULT_WRITER_READBACK_EN
   localparam logic [7:0] RdLat = 8'(RD_LATENCY);

   frw_state_e  ret_q, ret_d;
   logic [4:0]  vaddr_q, vaddr_d;
   logic [31:0] vdata_q, vdata_d;
   logic [7:0]  vcnt_q, vcnt_d;
   logic        err_q, err_d;

   // A verify that returns to FLUSH still belongs to the closing frame.
   assign flush_phase = (state_q == StFlush) || (state_q == StHdr) ||
                        ((state_q == StVerify) && (ret_q == StFlush));
   assign rb_err      = err_q;
`else
   logic unused_rd;
   assign unused_rd   = ^{mem_readdata, (RD_LATENCY == 0)};
   assign flush_phase = (state_q == StFlush) || (state_q == StHdr);
`endif

   assign box_ready = ready_en_q && !fifo_full && !flush_phase;
   assign fifo_push = box_valid && box_ready;
   assign busy      = (state_q == StFlush) || (state_q == StHdr);

   frw_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .push_i  (fifo_push),
      .wdata_i (box_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      ovf_d         = ovf_q;
      fcnt_d        = fcnt_q;
      fifo_pop      = 1'b0;
      acc           = 1'b0;
      wr            = 1'b0;
      addr          = '0;
      wdata         = '0;
      frame_dropped = 1'b0;
`ifdef FACE_RESULT_WRITER_READBACK_EN
      ret_d         = ret_q;
      vaddr_d       = vaddr_q;
      vdata_d       = vdata_q;
      vcnt_d        = vcnt_q;
      err_d         = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (frame_end) state_d = StFlush;
            else if (!fifo_empty) state_d = StWrbox;
         end
         StWrbox, StFlush: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (count_q < MaxCnt) begin
                  acc     = 1'b1;
                  addr    = BOX_BASE_ADDR + count_q[4:0];
                  wdata   = fifo_rdata;
                  count_d = count_q + 8'd1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            if (state_q == StWrbox) begin
               if (frame_end) state_d = StFlush;
               else if (fifo_empty) state_d = StIdle;
            end else begin
               frame_dropped = frame_end;
               if (fifo_empty) state_d = StHdr;
            end
         end
         StHdr: begin
            acc           = 1'b1;
            addr          = HDR_ADDR;
            wdata         = make_header(fcnt_q, ovf_q, count_q);
            count_d       = '0;
            ovf_d         = 1'b0;
            fcnt_d        = fcnt_q + 16'd1;
            frame_dropped = frame_end;
            state_d       = StIdle;
         end
`ifdef FACE_RESULT_WRITER_READBACK_EN
         StVerify: begin
            if (vcnt_q == 8'd0) begin
               acc  = 1'b1;
               addr = vaddr_q;
            end
            // frame_end seen mid-verify is deferred until the verify completes.
            if (frame_end) begin
               if (ret_q == StFlush) frame_dropped = 1'b1;
               else ret_d = StFlush;
            end
            if (vcnt_q == RdLat) begin
               if (mem_readdata != vdata_q) err_d = 1'b1;
               state_d = ret_d;
            end else begin
               vcnt_d = vcnt_q + 8'd1;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
`ifdef FACE_RESULT_WRITER_READBACK_EN
      wr = acc && (state_q != StVerify);
      if (wr) begin
         ret_d   = state_d;
         state_d = StVerify;
         vaddr_d = addr;
         vdata_d = wdata;
         vcnt_d  = '0;
      end
`else
      wr = acc;
`endif
   end

   assign mem_chipselect = acc;
   assign mem_write      = wr;
   assign mem_address    = addr;
   assign mem_writedata  = wdata;
   assign mem_byteenable = {4{acc}};
   assign mem_clken      = ready_en_q;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q    <= StIdle;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         fcnt_q     <= '0;
         ready_en_q <= 1'b0;
`ifdef FACE_RESULT_WRITER_READBACK_EN
         ret_q      <= StIdle;
         vaddr_q    <= '0;
         vdata_q    <= '0;
         vcnt_q     <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         fcnt_q     <= fcnt_d;
         ready_en_q <= 1'b1;
`ifdef FACE_RESULT_WRITER_READBACK_EN
         ret_q      <= ret_d;
         vaddr_q    <= vaddr_d;
         vdata_q    <= vdata_d;
         vcnt_q     <= vcnt_d;
         err_q      <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_face_result_writer.sv
// Scoreboard bench for face_result_writer: expected memory writes are queued as stimulus is driven.
module tb_face_result_writer;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n = 1'b1;
   logic        box_valid = 1'b0;
   logic        box_ready;
   logic [31:0] box_data = '0;
   logic        frame_end = 1'b0;
   logic [4:0]  mem_address;
   logic        mem_chipselect, mem_clken, mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata;
   logic        busy, frame_dropped;
`ifdef FACE_RESULT_WRITER_READBACK_EN
   logic        rb_err;
`endif

   always #5 clk_clk = ~clk_clk;

   face_result_writer #(
      .MAX_BOXES  (16),
      .FIFO_DEPTH (4),
      .RD_LATENCY (1)
   ) dut (
      .clk_clk        (clk_clk),
      .reset_reset_n  (reset_reset_n),
      .box_valid      (box_valid),
      .box_ready      (box_ready),
      .box_data       (box_data),
      .frame_end      (frame_end),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_clken      (mem_clken),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_byteenable (mem_byteenable),
      .mem_readdata   (mem_readdata),
      .busy           (busy),
      .frame_dropped  (frame_dropped)
`ifdef FACE_RESULT_WRITER_READBACK_EN
      ,
      .rb_err         (rb_err)
`endif
   );

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          m_cnt = 0;
   int          m_fcnt = 0;
   bit          m_ovf = 1'b0;
   int          drop_cnt = 0;
   int          hdr_cnt = 0;
   bit          corrupt = 1'b0;
   logic [31:0] mem_model [32];
   logic [31:0] rd_q = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Register-file model with one cycle read latency; can corrupt reads of address 2.
   always @(posedge clk_clk) begin
      if (mem_chipselect && mem_write) mem_model[mem_address] <= mem_writedata;
      if (mem_chipselect && !mem_write)
         rd_q <= mem_model[mem_address] ^ ((corrupt && mem_address == 5'd2) ? 32'h100 : 32'h0);
   end
   assign mem_readdata = rd_q;

   always @(negedge clk_clk) begin
      exp_t e;
      if (reset_reset_n) begin
         if (mem_chipselect && mem_write) begin
            if (mem_address == 5'd0) hdr_cnt++;
            check("wr_strobe", {27'b0, mem_byteenable, mem_clken}, 32'h1F);
            if (sb_q.size() == 0) begin
               check("unexpected_wr", sb_q.size(), 1);
            end else begin
               e = sb_q.pop_front();
               check("wr_addr", {27'b0, mem_address}, {27'b0, e.addr});
               check("wr_data", mem_writedata, e.data);
            end
         end
         if (frame_dropped) drop_cnt++;
      end
   end

   function automatic void push_box(input logic [31:0] d);
      if (m_cnt < 16) begin
         sb_q.push_back('{addr: 5'(1 + m_cnt), data: d});
         m_cnt++;
      end else begin
         m_ovf = 1'b1;
      end
   endfunction

   function automatic void push_hdr();
      logic [15:0] f;
      logic [7:0]  c;
      f = 16'(m_fcnt);
      c = 8'(m_cnt);
      sb_q.push_back('{addr: 5'd0, data: {f, m_ovf, 7'b0, c}});
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_fcnt = (m_fcnt + 1) % 65536;
   endfunction

   task automatic send_box(input logic [31:0] d, input bit fe);
      int t = 0;
      box_valid = 1'b1;
      box_data  = d;
      frame_end = fe;
      @(negedge clk_clk);
      while (!box_ready && t < 100) begin
         @(negedge clk_clk);
         t++;
      end
      if (!box_ready) begin
         check("ready_timeout", {31'b0, box_ready}, 1);
      end else begin
         push_box(d);
         if (fe) push_hdr();
      end
      @(posedge clk_clk);
      #1;
      box_valid = 1'b0;
      frame_end = 1'b0;
   endtask

   task automatic end_frame(input bit drop);
      frame_end = 1'b1;
      @(negedge clk_clk);
      if (drop) begin
         check("dropped_pulse", {31'b0, frame_dropped}, 1);
      end else begin
         check("no_drop", {31'b0, frame_dropped}, 0);
         push_hdr();
      end
      @(posedge clk_clk);
      #1;
      frame_end = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((sb_q.size() != 0 || busy) && t < 400) begin
         @(negedge clk_clk);
         t++;
      end
      if (t >= 400) check("drain_timeout", sb_q.size(), 0);
      repeat (6) @(negedge clk_clk);
      @(posedge clk_clk);
      #1;
   endtask

   task automatic check_reset_outs();
      check("rst_outs", {17'b0, mem_address, mem_chipselect, mem_clken, mem_write,
                         mem_byteenable, busy, frame_dropped, box_ready}, 0);
      check("rst_wdata", mem_writedata, 0);
`ifdef FACE_RESULT_WRITER_READBACK_EN
      check("rst_rb_err", {31'b0, rb_err}, 0);
`endif
   endtask

   task automatic do_reset();
      @(posedge clk_clk);
      #3;
      reset_reset_n = 1'b0;
      #1;
      check_reset_outs();
      sb_q.delete();
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_fcnt = 0;
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      @(posedge clk_clk);
      #1;
      check("ready_after_rst", {31'b0, box_ready}, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, h0, lat, t;
      #1 reset_reset_n = 1'b0;
      #2 check_reset_outs();
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      @(posedge clk_clk);
      #1;
      check("ready_after_rst", {31'b0, box_ready}, 1);

      // Basic frame, then an identical second frame.
      for (int f = 0; f < 2; f++) begin
         send_box(32'h0A0B0C01, 1'b0);
         send_box(32'h11111111, 1'b0);
         send_box(32'h22222222, 1'b0);
         end_frame(1'b0);
         wait_idle();
         check("mem_box1", mem_model[1], 32'h0A0B0C01);
         check("mem_box3", mem_model[3], 32'h22222222);
         check("mem_hdr", mem_model[0], (f == 0) ? 32'h0000_0003 : 32'h0001_0003);
      end

      // Acceptance-to-write latency from an empty FIFO.
      box_valid = 1'b1;
      box_data  = 32'h3333_4444;
      @(negedge clk_clk);
      check("lat_ready", {31'b0, box_ready}, 1);
      push_box(32'h3333_4444);
      @(posedge clk_clk);
      #1;
      box_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_clk);
         if (mem_write && lat == 0) lat = k;
      end
      check("wr_latency", {31'b0, (lat >= 1 && lat <= 2)}, 1);
      wait_idle();

      // Box accepted in the same cycle as frame_end belongs to the ending frame.
      send_box(32'h5555_6666, 1'b1);
      wait_idle();
      check("same_cycle_hdr", mem_model[0], 32'h0002_0002);

      // Overflow: 20 boxes with room for 16.
      do_reset();
      for (int i = 0; i < 20; i++) send_box(32'h1000_0000 + 32'(i), 1'b0);
      end_frame(1'b0);
      wait_idle();
      check("ovf_hdr", mem_model[0], 32'h0000_8010);
      check("ovf_last", mem_model[16], 32'h1000_000F);

      // frame_end while flushing is dropped and yields a single header.
      d0 = drop_cnt;
      h0 = hdr_cnt;
      send_box(32'h7777_0001, 1'b0);
      send_box(32'h7777_0002, 1'b0);
      end_frame(1'b0);
      end_frame(1'b1);
      wait_idle();
      check("drop_count", 32'(drop_cnt - d0), 1);
      check("hdr_count", 32'(hdr_cnt - h0), 1);

      // Reset mid-frame abandons it; the next frame starts from a clean count.
      send_box(32'h8888_0001, 1'b0);
      send_box(32'h8888_0002, 1'b0);
      t = 0;
      while (sb_q.size() != 0 && t < 100) begin
         @(negedge clk_clk);
         t++;
      end
      check("pre_rst_writes", sb_q.size(), 0);
      h0 = hdr_cnt;
      do_reset();
      repeat (5) @(posedge clk_clk);
      #1;
      check("no_hdr_on_rst", 32'(hdr_cnt - h0), 0);
      send_box(32'h9999_0001, 1'b0);
      end_frame(1'b0);
      wait_idle();
      check("post_rst_hdr", mem_model[0], 32'h0000_0001);

`ifdef FACE_RESULT_WRITER_READBACK_EN
      do_reset();
      corrupt = 1'b1;
      check("rb_err_clear", {31'b0, rb_err}, 0);
      send_box(32'hAAAA_0001, 1'b0);
      send_box(32'hAAAA_0002, 1'b0);
      send_box(32'hAAAA_0003, 1'b0);
      end_frame(1'b0);
      wait_idle();
      check("rb_err_set", {31'b0, rb_err}, 1);
      corrupt = 1'b0;
      send_box(32'hBBBB_0001, 1'b0);
      end_frame(1'b0);
      wait_idle();
      check("rb_err_sticky", {31'b0, rb_err}, 1);
      do_reset();
      check("rb_err_reset", {31'b0, rb_err}, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
